axi4_lite_regfile: RTL and testbench
====================================

Name: axi4_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register bank.
- Terminates one AXI4-Lite slave port and exposes NUM_REGS registers to fabric logic.
- Each register is one of three per-register modes: read/write, read-only (hardware-driven), or write-1-to-clear (hardware-set status).
- Supports 32/64-bit data, byte strobes, address-range decode with error responses, and independent read/write channels. Sits between the control-plane interconnect and block-level CSRs.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; only 32 or 64 legal (elaboration error otherwise).
- NUM_REGS, 16, number of registers (1..256).
- BASE_ADDR, 0, byte address of register 0; must be aligned to NUM_REGS*DATA_WIDTH/8.
- RO_MASK, 0, bit i=1 makes register i read-only.
- W1C_MASK, 0, bit i=1 makes register i write-1-to-clear; RO_MASK takes precedence if both set.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  slave-side AXI4-Lite  standard widths (STRB_WIDTH=DATA_WIDTH/8)
- reg_out  out  NUM_REGS*DATA_WIDTH  current value of every register, register i at slice i
- reg_in  in  NUM_REGS*DATA_WIDTH  hardware value returned on reads of RO registers
- hw_set  in  NUM_REGS*DATA_WIDTH  per-bit set strobes for W1C registers; ignored for other modes
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on a successful software write

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All registers, bvalid, rvalid, wr_pulse, bresp, rresp and rdata are 0.
  - awready, wready and arready are 0 while rst is high and 1 in the first cycle after release.
- awprot and arprot are accepted and ignored.
- Decode: index = (addr - BASE_ADDR) >> log2(STRB_WIDTH). Low address bits are ignored, so unaligned access hits the containing word. Address outside [BASE_ADDR, BASE_ADDR + NUM_REGS*STRB_WIDTH) decodes as miss.
- Write channel FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: AW and W captured independently into holding registers. awready stays high until AW is captured; wready stays high until W is captured.
  - Commit occurs on the clock edge at which both are held, or become held at that edge. Same-cycle AW+W handshake at cycle N means commit at the end of N, with bvalid=1 from N+1.
  - Then move to W_RESP.
  - W_RESP: awready=wready=0. bvalid is held with stable bresp until bready. On the handshake edge, go to W_COLLECT and clear the holding registers; readies are high the next cycle.
- Write effect:
  - RW: byte lanes with wstrb=1 take wdata; bresp=OKAY (00).
  - W1C: bits set in (wdata AND strobe-expanded mask) are cleared; bresp=OKAY.
  - RO: no change; bresp=SLVERR (10).
  - Miss: no change; bresp=DECERR (11).
  - wstrb=0 on RW/W1C: no change, bresp=OKAY, wr_pulse still fires.
- wr_pulse[i] is high for exactly one cycle, aligned with the first bvalid cycle, only for OKAY writes.
- hw_set:
  - Every cycle, W1C bits with hw_set=1 become 1.
  - Same-cycle software clear and hw_set on one bit: set wins.
- Read channel FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. A handshake at cycle N registers rdata/rresp and sets rvalid=1 from N+1.
  - R_RESP: arready=0. rdata/rresp are held until rready, then return to R_IDLE.
- Read data:
  - RW/W1C: register value. RO: reg_in slice sampled at the AR handshake edge. Response OKAY for all three.
  - Miss: rdata=0, rresp=DECERR.
- Read/write collision: read and write are fully independent. If an AR handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
- Reset asserted mid-transaction: all in-flight transactions are dropped, FSMs return to idle states, and no response is issued.
- Only one outstanding transaction per direction; no reordering.

Test Plan:
- Reset, then AW+W same cycle to BASE_ADDR+0x4 with wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> bvalid at N+1, bresp=00, reg_out[1]=0xDEADBEEF, wr_pulse[1] one cycle; readback gives 0xDEADBEEF/OKAY.
- W handshake 3 cycles before AW, wstrb=0x2, wdata=0x0000AB00, prior value 0x11223344 -> value 0x1122AB44, bvalid the cycle after the AW handshake; awready/wready low while bready held 0 for 5 cycles.
- W1C reg 2 = 0: pulse hw_set bits 0x5 -> read 0x5; write 0x1 with hw_set bit0 asserted the same cycle -> bit0 remains 1; write 0x4 alone -> read 0x1.
- Write to RO reg 3 -> bresp=10, reg unchanged, no wr_pulse; read reg 3 with reg_in=0xCAFE0001 -> rdata=0xCAFE0001, OKAY.
- Write and read at BASE_ADDR+NUM_REGS*4 -> bresp=11; rresp=11, rdata=0; all registers unchanged.
- DATA_WIDTH=64, NUM_REGS=4: AR handshake and write commit to reg 0 on the same edge -> old value returned; then assert rst with rvalid=1 and rready=0 -> rvalid and registers cleared immediately, arready=1 in the first cycle after release.

Source files
------------

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite slave-side bundle for the register bank.
// Handshake rule on every channel: a beat transfers on a rising clk edge where valid && ready are both high.
interface axi4_lite_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register bank with per-register RW / RO / W1C modes.
// Write and read channels are independent FSMs, one outstanding transaction each.
module axi4_lite_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [255:0]          RO_MASK    = '0,
    parameter logic [255:0]          W1C_MASK   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi4_lite_regfile_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [63:0] SPAN = 64'(NUM_REGS * STRB_WIDTH);
    localparam logic [NUM_REGS-1:0] RO_BITS  = RO_MASK[NUM_REGS-1:0];
    localparam logic [NUM_REGS-1:0] W1C_BITS = W1C_MASK[NUM_REGS-1:0] & ~RO_MASK[NUM_REGS-1:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("axi4_lite_regfile: DATA_WIDTH must be 32 or 64");
        end
        if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_count
            $error("axi4_lite_regfile: NUM_REGS must be in 1..256");
        end
    endgenerate

    typedef enum logic {W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  aw_rdy, w_rdy, ar_rdy;
    logic                  aw_fire, w_fire, ar_fire, commit, b_fire;

    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data, c_mask;
    logic [STRB_WIDTH-1:0] c_strb;
    logic                  c_hit, r_hit;
    logic [IDX_W-1:0]      c_idx, r_idx;
    logic [1:0]            c_resp;
    logic [NUM_REGS-1:0]   wsel;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  unused_bits;

    // Widened to 64 bits so BASE_ADDR + span cannot wrap near the top of the address map.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        logic [63:0] wide;
        wide = 64'(a);
        return (wide >= 64'(BASE_ADDR)) && (wide < 64'(BASE_ADDR) + SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [63:0] off;
        off = 64'(a) - 64'(BASE_ADDR);
        return IDX_W'(off >> LANE_SHIFT);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_COLLECT;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next     = w_state;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        commit     = 1'b0;
        b_fire     = 1'b0;
        bus.bvalid = 1'b0;
        case (w_state)
            W_COLLECT: begin
                aw_rdy  = !rst && !aw_held;
                w_rdy   = !rst && !w_held;
                aw_fire = bus.awvalid && aw_rdy;
                w_fire  = bus.wvalid && w_rdy;
                commit  = (aw_held || aw_fire) && (w_held || w_fire);
                if (commit) w_next = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                b_fire     = bus.bready;
                if (bus.bready) w_next = W_COLLECT;
            end
            default: w_next = W_COLLECT;
        endcase
    end

    always_comb begin
        r_next      = r_state;
        ar_rdy      = 1'b0;
        ar_fire     = 1'b0;
        bus.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy  = !rst;
                ar_fire = bus.arvalid && ar_rdy;
                if (ar_fire) r_next = R_RESP;
            end
            R_RESP: begin
                bus.rvalid = 1'b1;
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // The committing beat may come straight off the bus or from the holding registers.
    always_comb begin
        c_addr = aw_held ? aw_addr_q : bus.awaddr;
        c_data = w_held ? w_data_q : bus.wdata;
        c_strb = w_held ? w_strb_q : bus.wstrb;
        c_mask = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            c_mask[b*8 +: 8] = {8{c_strb[b]}};
        end
        c_hit = addr_hit(c_addr);
        c_idx = addr_idx(c_addr);
        if (!c_hit)              c_resp = RESP_DECERR;
        else if (RO_BITS[c_idx]) c_resp = RESP_SLVERR;
        else                     c_resp = RESP_OKAY;
        wsel = '0;
        if (commit && c_resp == RESP_OKAY) wsel[c_idx] = 1'b1;
        r_hit = addr_hit(bus.araddr);
        r_idx = addr_idx(bus.araddr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= wsel;
            if (commit) bresp_q <= c_resp;
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= bus.awaddr;
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= bus.wdata;
                    w_strb_q <= bus.wstrb;
                end
            end
        end
    end

    // hw_set is OR-ed in after the software clear, so a same-cycle set always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (W1C_BITS[i]) begin
                    regs[i] <= (regs[i] & ~(wsel[i] ? (c_data & c_mask) : '0))
                             | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (!RO_BITS[i] && wsel[i]) begin
                    regs[i] <= (regs[i] & ~c_mask) | (c_data & c_mask);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            if (!r_hit) begin
                rdata_q <= '0;
                rresp_q <= RESP_DECERR;
            end else begin
                rdata_q <= RO_BITS[r_idx] ? reg_in[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] : regs[r_idx];
                rresp_q <= RESP_OKAY;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.arready = ar_rdy;
    assign bus.bresp   = bresp_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign unused_bits = ^{bus.awprot, bus.arprot, hw_set};
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Bench for axi4_lite_regfile: a 32-bit/16-register instance and a 64-bit/4-register instance.
// Expected values come from a behavioural register model and fixed constants.
module tb_axi4_lite_regfile;
    localparam int            NA     = 16;
    localparam logic [31:0]   BASE_A = 32'h0000_1000;
    localparam logic [255:0]  RO_A   = 256'h18;
    localparam logic [255:0]  W1C_A  = 256'h14;
    localparam logic [31:0]   BASE_B = 32'h0000_0200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    axi4_lite_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    axi4_lite_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus_b ();
    logic [NA*32-1:0] reg_out_a, reg_in_a, hw_set_a;
    logic [NA-1:0]    wr_pulse_a;
    logic [4*64-1:0]  reg_out_b, reg_in_b, hw_set_b;
    logic [3:0]       wr_pulse_b;

    axi4_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NA), .BASE_ADDR(BASE_A),
                        .RO_MASK(RO_A), .W1C_MASK(W1C_A)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .reg_out(reg_out_a), .reg_in(reg_in_a),
        .hw_set(hw_set_a), .wr_pulse(wr_pulse_a));

    axi4_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_REGS(4), .BASE_ADDR(BASE_B),
                        .RO_MASK('0), .W1C_MASK('0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .reg_out(reg_out_b), .reg_in(reg_in_b),
        .hw_set(hw_set_b), .wr_pulse(wr_pulse_b));

    int errors = 0;
    int checks = 0;
    logic [31:0] model [NA];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [NA-1:0] pulse);
        logic [31:0] mask;
        int idx;
        mask = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
        pulse = '0;
        if (addr < BASE_A || addr >= BASE_A + NA*4) begin
            resp = 2'b11;
        end else begin
            idx = int'((addr - BASE_A) / 4);
            if (RO_A[idx]) begin
                resp = 2'b10;
            end else begin
                resp = 2'b00;
                pulse[idx] = 1'b1;
                if (W1C_A[idx]) model[idx] = model[idx] & ~(data & mask);
                else            model[idx] = (model[idx] & ~mask) | (data & mask);
            end
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx;
        if (addr < BASE_A || addr >= BASE_A + NA*4) begin
            data = '0;
            resp = 2'b11;
        end else begin
            idx  = int'((addr - BASE_A) / 4);
            data = RO_A[idx] ? reg_in_a[idx*32 +: 32] : model[idx];
            resp = 2'b00;
        end
    endtask

    function automatic logic [NA*32-1:0] model_flat();
        logic [NA*32-1:0] r;
        for (int i = 0; i < NA; i++) r[i*32 +: 32] = model[i];
        return r;
    endfunction

    // ---------------- drivers (instance A) ----------------
    task automatic write_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int stall,
                           output logic [1:0] resp, output logic [NA-1:0] pulse,
                           output logic [NA-1:0] pulse_after, output int lat,
                           output bit stall_ok, output int aw_cyc);
        int cyc = 0;
        bit aw_done = 0;
        bit w_done = 0;
        bus_a.awaddr = addr;
        bus_a.wdata  = data;
        bus_a.wstrb  = strb;
        bus_a.bready = 1'b0;
        stall_ok = 1'b1;
        aw_cyc = -1;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus_a.awvalid = !aw_done && cyc >= aw_dly;
            bus_a.wvalid  = !w_done && cyc >= w_dly;
            #1;
            if (bus_a.awvalid && bus_a.awready) begin aw_done = 1; aw_cyc = cyc; end
            if (bus_a.wvalid && bus_a.wready) w_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        lat = 1;
        while (!bus_a.bvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!bus_a.bvalid) begin
            errors++;
            $display("FAIL write_timeout: addr %h got bvalid 0 required 1", addr);
        end
        resp  = bus_a.bresp;
        pulse = wr_pulse_a;
        repeat (stall) begin
            @(posedge clk); #1;
            if (bus_a.awready || bus_a.wready || !bus_a.bvalid || bus_a.bresp !== resp || wr_pulse_a != '0)
                stall_ok = 1'b0;
        end
        bus_a.bready = 1'b1;
        @(posedge clk); #1;
        bus_a.bready = 1'b0;
        pulse_after = wr_pulse_a;
    endtask

    task automatic read_a(input logic [31:0] addr, input int ar_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
        int cyc = 0;
        bit done = 0;
        bus_a.araddr = addr;
        bus_a.rready = 1'b0;
        while (!done && cyc < 40) begin
            bus_a.arvalid = cyc >= ar_dly;
            #1;
            if (bus_a.arvalid && bus_a.arready) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        bus_a.arvalid = 1'b0;
        lat = 1;
        while (!bus_a.rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!bus_a.rvalid) begin
            errors++;
            $display("FAIL read_timeout: addr %h got rvalid 0 required 1", addr);
        end
        data = bus_a.rdata;
        resp = bus_a.rresp;
        bus_a.rready = 1'b1;
        @(posedge clk); #1;
        bus_a.rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_a.awaddr = '0; bus_a.awprot = '0; bus_a.awvalid = 0; bus_a.wdata = '0; bus_a.wstrb = '0;
        bus_a.wvalid = 0; bus_a.bready = 0; bus_a.araddr = '0; bus_a.arprot = '0; bus_a.arvalid = 0;
        bus_a.rready = 0;
        bus_b.awaddr = '0; bus_b.awprot = '0; bus_b.awvalid = 0; bus_b.wdata = '0; bus_b.wstrb = '0;
        bus_b.wvalid = 0; bus_b.bready = 0; bus_b.araddr = '0; bus_b.arprot = 3'b101; bus_b.arvalid = 0;
        bus_b.rready = 0;
        reg_in_a = '0; hw_set_a = '0; reg_in_b = '0; hw_set_b = '0;
        for (int i = 0; i < NA; i++) model[i] = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_a.awready, bus_a.wready, bus_a.arready, bus_b.awready, bus_b.wready, bus_b.arready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_readies: got %b required 000000",
                     {bus_a.awready, bus_a.wready, bus_a.arready, bus_b.awready, bus_b.wready, bus_b.arready});
        end
        checks++;
        if ({bus_a.bvalid, bus_a.rvalid, bus_a.bresp, bus_a.rresp} !== 6'b0 || bus_a.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: got bvalid %b rvalid %b bresp %b rresp %b rdata %h required all 0",
                     bus_a.bvalid, bus_a.rvalid, bus_a.bresp, bus_a.rresp, bus_a.rdata);
        end
        checks++;
        if (reg_out_a !== '0 || wr_pulse_a !== '0 || reg_out_b !== '0) begin
            errors++;
            $display("FAIL reset_regs: got reg_out_a %h wr_pulse %h required 0", reg_out_a, wr_pulse_a);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({bus_a.awready, bus_a.wready, bus_a.arready, bus_b.awready, bus_b.wready, bus_b.arready} !== 6'b111111) begin
            errors++;
            $display("FAIL release_readies: got %b required 111111",
                     {bus_a.awready, bus_a.wready, bus_a.arready, bus_b.awready, bus_b.wready, bus_b.arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_write();
        logic [1:0] resp, eresp; logic [NA-1:0] pulse, pa, epulse; int lat, awc; bit ok;
        logic [31:0] data;
        bus_a.awprot = 3'b111;
        model_write(BASE_A + 4, 32'hDEAD_BEEF, 4'hF, eresp, epulse);
        write_a(BASE_A + 4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL basic_b_latency: got %0d required 1", lat); end
        checks++;
        if (resp !== eresp) begin errors++; $display("FAIL basic_bresp: got %b required %b", resp, eresp); end
        checks++;
        if (pulse !== 16'h0002 || pa !== 16'h0) begin
            errors++; $display("FAIL basic_pulse: got %h then %h required 0002 then 0000", pulse, pa);
        end
        checks++;
        if (reg_out_a[63:32] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL basic_reg_out: got %h required deadbeef", reg_out_a[63:32]);
        end
        read_a(BASE_A + 4, 0, data, resp, lat);
        checks++;
        if (data !== 32'hDEAD_BEEF || resp !== 2'b00 || lat != 1) begin
            errors++; $display("FAIL basic_readback: got %h/%b lat %0d required deadbeef/00 lat 1", data, resp, lat);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp, eresp; logic [NA-1:0] pulse, pa, epulse; int lat, awc; bit ok;
        model_write(BASE_A + 20, 32'h1122_3344, 4'hF, eresp, epulse);
        write_a(BASE_A + 20, 32'h1122_3344, 4'hF, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
        model_write(BASE_A + 20, 32'h0000_AB00, 4'h2, eresp, epulse);
        write_a(BASE_A + 20, 32'h0000_AB00, 4'h2, 3, 0, 5, resp, pulse, pa, lat, ok, awc);
        checks++;
        if (awc != 3 || lat != 1) begin
            errors++; $display("FAIL wfirst_timing: got aw cycle %0d b latency %0d required 3 and 1", awc, lat);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wfirst_stall: got readies/bvalid unstable required held"); end
        checks++;
        if (reg_out_a[5*32 +: 32] !== 32'h1122_AB44 || resp !== 2'b00 || pulse !== 16'h0020) begin
            errors++; $display("FAIL wfirst_value: got %h/%b/%h required 1122ab44/00/0020",
                               reg_out_a[5*32 +: 32], resp, pulse);
        end
        checks++;
        if (!(bus_a.awready && bus_a.wready) || bus_a.bvalid) begin
            errors++; $display("FAIL wfirst_recover: got aw %b w %b bvalid %b required 1 1 0",
                               bus_a.awready, bus_a.wready, bus_a.bvalid);
        end
        model_write(BASE_A + 24, 32'h5566_7788, 4'h9, eresp, epulse);
        write_a(BASE_A + 24, 32'h5566_7788, 4'h9, 0, 2, 1, resp, pulse, pa, lat, ok, awc);
        checks++;
        if (reg_out_a !== model_flat() || lat != 1 || !ok) begin
            errors++; $display("FAIL awfirst_value: got %h lat %0d required %h lat 1",
                               reg_out_a[6*32 +: 32], lat, model[6]);
        end
    endtask

    task automatic test_w1c();
        logic [1:0] resp; logic [NA-1:0] pulse, pa; int lat, awc; bit ok; logic [31:0] data;
        hw_set_a[2*32 +: 32] = 32'h5;
        @(posedge clk); #1;
        hw_set_a[2*32 +: 32] = 32'h0;
        read_a(BASE_A + 8, 0, data, resp, lat);
        checks++;
        if (data !== 32'h5 || resp !== 2'b00) begin
            errors++; $display("FAIL w1c_hwset: got %h/%b required 00000005/00", data, resp);
        end
        hw_set_a[2*32 +: 32] = 32'h1;
        write_a(BASE_A + 8, 32'h1, 4'hF, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
        hw_set_a[2*32 +: 32] = 32'h0;
        read_a(BASE_A + 8, 0, data, resp, lat);
        checks++;
        if (data !== 32'h5 || pulse !== 16'h0004) begin
            errors++; $display("FAIL w1c_set_wins: got %h pulse %h required 00000005 pulse 0004", data, pulse);
        end
        write_a(BASE_A + 8, 32'h4, 4'hF, 1, 0, 0, resp, pulse, pa, lat, ok, awc);
        read_a(BASE_A + 8, 1, data, resp, lat);
        checks++;
        if (data !== 32'h1 || resp !== 2'b00) begin
            errors++; $display("FAIL w1c_clear: got %h/%b required 00000001/00", data, resp);
        end
        write_a(BASE_A + 8, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
        checks++;
        if (reg_out_a[2*32 +: 32] !== 32'h1 || resp !== 2'b00 || pulse !== 16'h0004) begin
            errors++; $display("FAIL w1c_zero_strb: got %h/%b/%h required 00000001/00/0004",
                               reg_out_a[2*32 +: 32], resp, pulse);
        end
        model[2] = 32'h1;
    endtask

    task automatic test_ro();
        logic [1:0] resp; logic [NA-1:0] pulse, pa; int lat, awc; bit ok; logic [31:0] data;
        reg_in_a[3*32 +: 32] = 32'hCAFE_0001;
        reg_in_a[4*32 +: 32] = 32'h1234_5678;
        write_a(BASE_A + 12, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
        checks++;
        if (resp !== 2'b10 || pulse !== '0 || pa !== '0 || reg_out_a !== model_flat()) begin
            errors++; $display("FAIL ro_write: got %b pulse %h reg %h required 10 pulse 0000 reg %h",
                               resp, pulse, reg_out_a[3*32 +: 32], model[3]);
        end
        read_a(BASE_A + 12, 0, data, resp, lat);
        checks++;
        if (data !== 32'hCAFE_0001 || resp !== 2'b00) begin
            errors++; $display("FAIL ro_read: got %h/%b required cafe0001/00", data, resp);
        end
        hw_set_a[4*32 +: 32] = 32'hFFFF_FFFF;
        write_a(BASE_A + 16, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
        hw_set_a[4*32 +: 32] = 32'h0;
        read_a(BASE_A + 16, 0, data, resp, lat);
        checks++;
        if (resp !== 2'b00 || data !== 32'h1234_5678 || reg_out_a[4*32 +: 32] !== 32'h0 || pulse !== '0) begin
            errors++; $display("FAIL ro_precedence: got rdata %h reg %h pulse %h required 12345678 0 0",
                               data, reg_out_a[4*32 +: 32], pulse);
        end
    endtask

    task automatic test_miss();
        logic [1:0] resp, eresp; logic [NA-1:0] pulse, pa, epulse; int lat, awc; bit ok;
        logic [31:0] data, edata;
        logic [31:0] addrs [4];
        addrs[0] = BASE_A + NA*4; addrs[1] = BASE_A - 4; addrs[2] = BASE_A + 7; addrs[3] = BASE_A + 60;
        reg_in_a = {NA{32'hA5A5_5A5A}};
        reg_in_a[3*32 +: 32] = 32'hCAFE_0001;
        for (int k = 0; k < 4; k++) begin
            model_write(addrs[k], 32'h3C3C_0000 + k, 4'hF, eresp, epulse);
            write_a(addrs[k], 32'h3C3C_0000 + k, 4'hF, 0, 0, 0, resp, pulse, pa, lat, ok, awc);
            checks++;
            if (resp !== eresp || pulse !== epulse || reg_out_a !== model_flat()) begin
                errors++; $display("FAIL decode_write_%0d: got %b pulse %h required %b pulse %h",
                                   k, resp, pulse, eresp, epulse);
            end
            model_read(addrs[k], edata, eresp);
            read_a(addrs[k], 0, data, resp, lat);
            checks++;
            if (data !== edata || resp !== eresp) begin
                errors++; $display("FAIL decode_read_%0d: got %h/%b required %h/%b", k, data, resp, edata, eresp);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, eresp; logic [NA-1:0] pulse, pa, epulse; int lat, awc; bit ok;
        logic [31:0] addr, data, wdat, edata; logic [3:0] strb;
        for (int i = 0; i < NA; i++) reg_in_a[i*32 +: 32] = $urandom;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                8:       addr = BASE_A + NA*4 + 4*$urandom_range(0, 3);
                9:       addr = BASE_A - 1 - $urandom_range(0, 7);
                default: addr = BASE_A + 4*$urandom_range(0, NA-1) + $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                wdat = $urandom;
                strb = 4'($urandom_range(0, 15));
                model_write(addr, wdat, strb, eresp, epulse);
                write_a(addr, wdat, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                        resp, pulse, pa, lat, ok, awc);
                checks++;
                if (resp !== eresp || pulse !== epulse || pa !== '0 || !ok || reg_out_a !== model_flat()) begin
                    errors++; $display("FAIL rand_write_%0d: addr %h got %b pulse %h required %b pulse %h",
                                       it, addr, resp, pulse, eresp, epulse);
                end
            end else begin
                model_read(addr, edata, eresp);
                read_a(addr, $urandom_range(0, 2), data, resp, lat);
                checks++;
                if (data !== edata || resp !== eresp || lat != 1) begin
                    errors++; $display("FAIL rand_read_%0d: addr %h got %h/%b required %h/%b",
                                       it, addr, data, resp, edata, eresp);
                end
            end
        end
    endtask

    task automatic test_wide_collision();
        logic [63:0] old_v, new_v;
        old_v = 64'h0123_4567_89AB_CDEF;
        new_v = 64'hFEDC_BA98_7654_3210;
        bus_b.bready = 1'b1;
        bus_b.awaddr = BASE_B; bus_b.wdata = old_v; bus_b.wstrb = 8'hFF;
        bus_b.awvalid = 1'b1; bus_b.wvalid = 1'b1;
        @(posedge clk); #1;
        bus_b.awvalid = 1'b0; bus_b.wvalid = 1'b0;
        checks++;
        if (!bus_b.bvalid || bus_b.bresp !== 2'b00 || wr_pulse_b !== 4'b0001) begin
            errors++; $display("FAIL wide_write: got bvalid %b bresp %b pulse %b required 1 00 0001",
                               bus_b.bvalid, bus_b.bresp, wr_pulse_b);
        end
        @(posedge clk); #1;
        bus_b.awaddr = BASE_B + 3; bus_b.wdata = new_v;
        bus_b.araddr = BASE_B + 5;
        bus_b.awvalid = 1'b1; bus_b.wvalid = 1'b1; bus_b.arvalid = 1'b1;
        @(posedge clk); #1;
        bus_b.awvalid = 1'b0; bus_b.wvalid = 1'b0; bus_b.arvalid = 1'b0;
        checks++;
        if (!bus_b.rvalid || bus_b.rdata !== old_v || bus_b.rresp !== 2'b00) begin
            errors++; $display("FAIL wide_collision_read: got %b %h/%b required 1 %h/00",
                               bus_b.rvalid, bus_b.rdata, bus_b.rresp, old_v);
        end
        checks++;
        if (reg_out_b[63:0] !== new_v || !bus_b.bvalid) begin
            errors++; $display("FAIL wide_collision_write: got %h required %h", reg_out_b[63:0], new_v);
        end
        @(posedge clk); #1;
        checks++;
        if (!bus_b.rvalid || bus_b.rdata !== old_v || bus_b.arready) begin
            errors++; $display("FAIL wide_rdata_hold: got %b %h arready %b required 1 %h 0",
                               bus_b.rvalid, bus_b.rdata, bus_b.arready, old_v);
        end
        rst_b = 1'b1;
        #1;
        checks++;
        if (bus_b.rvalid || bus_b.bvalid || reg_out_b !== '0 || bus_b.arready || wr_pulse_b !== '0) begin
            errors++; $display("FAIL wide_mid_reset: got rvalid %b bvalid %b reg0 %h arready %b required 0 0 0 0",
                               bus_b.rvalid, bus_b.bvalid, reg_out_b[63:0], bus_b.arready);
        end
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        checks++;
        if (!bus_b.arready || bus_b.rvalid || !bus_b.awready || !bus_b.wready) begin
            errors++; $display("FAIL wide_release: got arready %b rvalid %b required 1 0", bus_b.arready, bus_b.rvalid);
        end
        @(posedge clk); #1;
        bus_b.awaddr = BASE_B + 24; bus_b.wdata = '1; bus_b.wstrb = 8'hF0;
        bus_b.awvalid = 1'b1; bus_b.wvalid = 1'b1;
        @(posedge clk); #1;
        bus_b.awvalid = 1'b0; bus_b.wvalid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (reg_out_b[3*64 +: 64] !== 64'hFFFF_FFFF_0000_0000 || reg_out_b[191:0] !== '0) begin
            errors++; $display("FAIL wide_strobe: got %h required ffffffff00000000", reg_out_b[3*64 +: 64]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_w_before_aw();
        test_w1c();
        test_ro();
        test_miss();
        test_random();
        test_wide_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
